pipeline_ctrl: RTL and testbench

Stall/flush sequencer for the 5-stage RV32I pipeline; sits beside the forwarding unit and owns every pipeline-register enable and clear. It covers the hazards forwarding cannot resolve:
- load-use: one-cycle bubble;
- taken branch/jump resolved in E: flush D and E;
- multi-cycle data-memory access in M: freeze F..M until ack, with bounded timeout.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/mem_wait_fsm.sv | 65 ++++++
 rtl/pipeline_ctrl.sv | 97 +++++++++
 tb/tb_pipeline_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: opcode constants and the memory-wait FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef logic [0:0] mem_state_t;
  localparam mem_state_t RUN  = 1'b0;
  localparam mem_state_t WAIT = 1'b1;

endpackage

// File: rtl/mem_wait_fsm.sv
// Memory-wait sequencer: holds the pipeline while an M-stage data access is outstanding,
// releasing on ack or after MEM_TIMEOUT stall cycles (flagged by mem_err).
module mem_wait_fsm
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       DmemReqM,
  input  logic       DmemAckM,
  output logic       mem_stall,
  output logic       mem_err,
  output mem_state_t state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

  // Handshake: DmemReqM stays high while the M access is pending; DmemAckM marks the
  // cycle the access completes (same cycle as the request for a zero-wait access).
  mem_state_t    state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_nxt;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_stall    = 1'b0;
    mem_err      = 1'b0;
    case (state)
      RUN: begin
        if (DmemReqM && !DmemAckM) begin
          mem_stall    = 1'b1;
          wait_cnt_nxt = CW'(1);
          state_nxt    = WAIT;
        end
      end
      default: begin
        if (DmemAckM) begin
          wait_cnt_nxt = '0;
          state_nxt    = RUN;
        end else if (wait_cnt == TIMEOUT_VAL) begin
          mem_err      = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = RUN;
        end else begin
          mem_stall    = 1'b1;
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline (load-use, taken branch, memory wait).
// Optional perf counters StallCnt/FlushCnt are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrD,
  input  logic [31:0] InstrE,
  input  logic        BranchTakenE,
  input  logic        DmemReqM,
  input  logic        DmemAckM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemErrM,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
`endif
  output mem_state_t  mem_state
);

  logic [4:0] rs1D, rs2D, rdE;
  logic [6:0] opD, opE;
  logic       reads_rs1, reads_rs2, load_use;
  logic       mem_stall, mem_err;

  assign rs1D = InstrD[19:15];
  assign rs2D = InstrD[24:20];
  assign rdE  = InstrE[11:7];
  assign opD  = InstrD[6:0];
  assign opE  = InstrE[6:0];

  assign reads_rs1 = (opD != OP_LUI) && (opD != OP_AUIPC) && (opD != OP_JAL);
  assign reads_rs2 = (opD == OP_RTYPE) || (opD == OP_STORE) || (opD == OP_BRANCH);
  assign load_use  = (opE == OP_LOAD) && (rdE != 5'd0) &&
                     ((reads_rs1 && (rs1D == rdE)) || (reads_rs2 && (rs2D == rdE)));

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .DmemReqM  (DmemReqM),
    .DmemAckM  (DmemAckM),
    .mem_stall (mem_stall),
    .mem_err   (mem_err),
    .state     (mem_state)
  );

  // A frozen E keeps BranchTakenE high, so a branch under MemStall flushes on release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst_n) begin
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (BranchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign MemErrM = rst_n && mem_err;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF) StallCnt <= StallCnt + 32'd1;
      if (FlushD) FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MEM_TIMEOUT = 4); expected outputs queued per cycle and
// compared by an independent monitor on the falling edge.
module tb_pipeline_ctrl;
  import riscv_pkg::*;

  localparam int TO = 4;

  // Expected vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemErrM,state}
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] MS   = 9'b111100100;
  localparam logic [8:0] BR   = 9'b000011000;
  localparam logic [8:0] ERR  = 9'b000000010;
  localparam logic [8:0] STW  = 9'b000000001;

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] LW_X5    = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] LW_X0    = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] ADD_X5   = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] ADD_X0   = 32'h00000333;  // add x6,x0,x0
  localparam logic [31:0] LUI_R5   = 32'h000282B7;  // lui x5,0x28 (rs1 field = 5)
  localparam logic [31:0] SW_X5    = 32'h00512023;  // sw x5,0(x2)
  localparam logic [31:0] ADDI_I5  = 32'h00508393;  // addi x7,x1,5 (rs2 field = 5)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] InstrD = NOP;
  logic [31:0] InstrE = NOP;
  logic        BranchTakenE = 1'b0;
  logic        DmemReqM = 1'b0;
  logic        DmemAckM = 1'b0;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErrM;
  mem_state_t  mem_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  string      name_q[$];

  pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .InstrD       (InstrD),
    .InstrE       (InstrE),
    .BranchTakenE (BranchTakenE),
    .DmemReqM     (DmemReqM),
    .DmemAckM     (DmemAckM),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .MemErrM      (MemErrM),
`ifdef PIPE_CTRL_PERF_EN
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt),
`endif
    .mem_state    (mem_state)
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Driver: one call = one clock cycle of stimulus plus its expected response.
  task automatic step(input logic r, input logic [31:0] e, input logic [31:0] d,
                      input logic br, input logic req, input logic ack,
                      input logic [8:0] exp, input string nm);
    @(posedge clk);
    #1;
    rst_n        = r;
    InstrE       = e;
    InstrD       = d;
    BranchTakenE = br;
    DmemReqM     = req;
    DmemAckM     = ack;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] got, exp;
      string nm;
      got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErrM, mem_state};
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  task automatic check_cnt(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
`endif

  initial begin
    step(0, LW_X5,  ADD_X5,  0, 1, 0, NONE,      "reset_gates_outputs_0");
    step(0, LW_X5,  ADD_X5,  0, 1, 0, NONE,      "reset_gates_outputs_1");
    step(1, LW_X5,  ADD_X5,  0, 0, 0, LU,        "load_use_rs1");
    step(1, NOP,    NOP,     0, 0, 0, NONE,      "idle_after_bubble");
    step(1, LW_X5,  LUI_R5,  0, 0, 0, NONE,      "lui_no_rs1_read");
    step(1, LW_X0,  ADD_X0,  0, 0, 0, NONE,      "load_rd_x0");
    step(1, LW_X5,  SW_X5,   0, 0, 0, LU,        "load_use_store_rs2");
    step(1, LW_X5,  ADDI_I5, 0, 0, 0, NONE,      "itype_no_rs2_read");
    // Ack three cycles after request
    step(1, NOP, NOP, 0, 1, 0, MS,               "mem_wait_c1");
    step(1, NOP, NOP, 0, 1, 0, MS | STW,         "mem_wait_c2");
    step(1, NOP, NOP, 0, 1, 0, MS | STW,         "mem_wait_c3");
    step(1, NOP, NOP, 0, 1, 1, STW,              "mem_ack_release");
    step(1, NOP, NOP, 0, 0, 0, NONE,             "mem_back_to_run");
    step(1, NOP, NOP, 0, 1, 1, NONE,             "mem_zero_wait");
    step(1, NOP, NOP, 0, 0, 0, NONE,             "mem_zero_wait_run");
    // Timeout with no ack
    step(1, NOP, NOP, 0, 1, 0, MS,               "timeout_c1");
    step(1, NOP, NOP, 0, 1, 0, MS | STW,         "timeout_c2");
    step(1, NOP, NOP, 0, 1, 0, MS | STW,         "timeout_c3");
    step(1, NOP, NOP, 0, 1, 0, MS | STW,         "timeout_c4");
    step(1, NOP, NOP, 0, 1, 0, ERR | STW,        "timeout_release_err");
    step(1, NOP, NOP, 0, 1, 0, MS,               "timeout_reenter");
    step(1, NOP, NOP, 0, 1, 1, STW,              "reenter_ack");
    step(1, NOP, NOP, 0, 0, 0, NONE,             "reenter_run");
    // Branch priority
    step(1, LW_X5, ADD_X5, 1, 0, 0, BR,          "branch_over_load_use");
    step(1, NOP, NOP, 1, 1, 0, MS,               "branch_in_mem_c1");
    step(1, NOP, NOP, 1, 1, 0, MS | STW,         "branch_in_mem_c2");
    step(1, NOP, NOP, 1, 1, 1, BR | STW,         "branch_on_release");
    step(1, NOP, NOP, 0, 0, 0, NONE,             "branch_after_release");
    // Reset mid-WAIT
    step(1, NOP, NOP, 0, 1, 0, MS,               "rst_wait_c1");
    step(1, NOP, NOP, 0, 1, 0, MS | STW,         "rst_wait_c2");
    step(0, NOP, NOP, 0, 1, 0, STW,              "rst_in_wait_no_err");
    step(1, NOP, NOP, 0, 0, 0, NONE,             "rst_back_to_run");
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    check_cnt("stall_cnt_after_reset", StallCnt, 32'd0);
    check_cnt("flush_cnt_after_reset", FlushCnt, 32'd0);
`endif
    step(1, LW_X5, ADD_X5, 0, 0, 0, LU,          "perf_lu_1");
    step(1, LW_X5, SW_X5,  0, 0, 0, LU,          "perf_lu_2");
    step(1, LW_X5, ADD_X5, 0, 0, 0, LU,          "perf_lu_3");
    step(1, NOP,   NOP,    0, 0, 0, NONE,        "perf_idle");
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    check_cnt("stall_cnt_three_bubbles", StallCnt, 32'd3);
    check_cnt("flush_cnt_no_branch", FlushCnt, 32'd0);
`endif
    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
